// File: rtl/lmdpl_pkg.sv
// Shared types and helpers for the LMDPL gate array.
// Holds the FSM state enum, truth-table constants and table index helper.
package lmdpl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    // func[k] = f(a,b) with k = {b,a}
    localparam logic [3:0] FUNC_NOR  = 4'b0001;
    localparam logic [3:0] FUNC_AND  = 4'b1000;
    localparam logic [3:0] FUNC_XOR  = 4'b0110;
    localparam logic [3:0] FUNC_NAND = 4'b0111;
    localparam logic [3:0] FUNC_OR   = 4'b1110;

    function automatic logic [1:0] tbl_idx(input logic b, input logic a);
        return {b, a};
    endfunction

endpackage

// File: rtl/lmdpl_lane.sv
// One LMDPL lane: masked table generation plus dual-rail AND3/OR4 gate.
// Ports: func/m_in0/m_in1/m_out -> tbl_next; tbl + rails -> q_m, q_m_bar.
module lmdpl_lane
    import lmdpl_pkg::*;
(
    input  logic [3:0] func,
    input  logic       m_in0,
    input  logic       m_in1,
    input  logic       m_out,
    output logic [3:0] tbl_next,
    input  logic [3:0] tbl,
    input  logic       a_m,
    input  logic       a_m_bar,
    input  logic       b_m,
    input  logic       b_m_bar,
    output logic       q_m,
    output logic       q_m_bar
);

    logic [3:0] sel;

    // Entry k is addressed by the masked operand pair, so the unmasked
    // index is k ^ {m_in1, m_in0}; the output mask is folded in here.
    always_comb begin
        tbl_next = '0;
        for (int k = 0; k < 4; k++) begin
            tbl_next[k] = func[tbl_idx(m_in1, m_in0) ^ 2'(k)] ^ m_out;
        end
    end

    // Exactly one selector fires in EVAL; none while rails are precharged.
    always_comb begin
        sel                       = '0;
        sel[tbl_idx(1'b0, 1'b0)]  = b_m_bar & a_m_bar;
        sel[tbl_idx(1'b0, 1'b1)]  = b_m_bar & a_m;
        sel[tbl_idx(1'b1, 1'b0)]  = b_m     & a_m_bar;
        sel[tbl_idx(1'b1, 1'b1)]  = b_m     & a_m;
    end

    assign q_m     = |(tbl & sel);
    assign q_m_bar = |(~tbl & sel);

endmodule

// File: rtl/lmdpl_gate_array.sv
// WIDTH-lane masked dual-rail gate with runtime truth table.
// Ports: clk, rst, start/ready, func, in0/in1, masks -> out, out_m, out_valid.
module lmdpl_gate_array
    import lmdpl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] m_in0,
    input  logic [WIDTH-1:0] m_in1,
    input  logic [WIDTH-1:0] m_out,
    output logic             ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_m
);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] mo_r;
    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] a_m_bar;
    logic [WIDTH-1:0] b_m;
    logic [WIDTH-1:0] b_m_bar;
    logic [WIDTH-1:0] q_m;
    logic [WIDTH-1:0] q_m_bar;
    logic [3:0]       tbl_r  [WIDTH];
    logic [3:0]       tbl_nx [WIDTH];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = PRE;
            PRE:     state_nx = EVAL;
            EVAL:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            mo_r    <= '0;
            a_m     <= '0;
            a_m_bar <= '0;
            b_m     <= '0;
            b_m_bar <= '0;
            out     <= '0;
            out_m   <= '0;
            for (int i = 0; i < WIDTH; i++) tbl_r[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= in0 ^ m_in0;
                        b_r     <= in1 ^ m_in1;
                        mo_r    <= m_out;
                        a_m     <= '0;
                        a_m_bar <= '0;
                        b_m     <= '0;
                        b_m_bar <= '0;
                        for (int i = 0; i < WIDTH; i++) tbl_r[i] <= tbl_nx[i];
                    end
                end
                PRE: begin
                    a_m     <= a_r;
                    a_m_bar <= ~a_r;
                    b_m     <= b_r;
                    b_m_bar <= ~b_r;
                end
                EVAL: begin
                    // Each output register is fed from its own rail;
                    // in EVAL q_m_bar == ~q_m, so out == q_m ^ mo_r.
                    out_m <= q_m;
                    out   <= q_m_bar ^ ~mo_r;
                end
                DONE: begin
                    a_m     <= '0;
                    a_m_bar <= '0;
                    b_m     <= '0;
                    b_m_bar <= '0;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        lmdpl_lane u_lane (
            .func     (func),
            .m_in0    (m_in0[i]),
            .m_in1    (m_in1[i]),
            .m_out    (m_out[i]),
            .tbl_next (tbl_nx[i]),
            .tbl      (tbl_r[i]),
            .a_m      (a_m[i]),
            .a_m_bar  (a_m_bar[i]),
            .b_m      (b_m[i]),
            .b_m_bar  (b_m_bar[i]),
            .q_m      (q_m[i]),
            .q_m_bar  (q_m_bar[i])
        );
    end

endmodule

// File: tb/tb_lmdpl_gate_array.sv
// Self-checking bench for lmdpl_gate_array against a phase-counter model.
// Directed cases plus randomized start/rst/operand/mask traffic.
module tb_lmdpl_gate_array;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] func;
    logic [7:0] in0, in1, m_in0, m_in1, m_out;
    logic       ready, out_valid;
    logic [7:0] out, out_m;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: ph = cycles since accept (0 = idle), captured result.
    int       ph = 0;
    logic [7:0] cap_o = '0, cap_m = '0;
    logic [7:0] exp_o = '0, exp_m = '0;

    always #5 clk = ~clk;

    lmdpl_gate_array #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .func      (func),
        .in0       (in0),
        .in1       (in1),
        .m_in0     (m_in0),
        .m_in1     (m_in1),
        .m_out     (m_out),
        .ready     (ready),
        .out_valid (out_valid),
        .out       (out),
        .out_m     (out_m)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic logic [7:0] ref_f(input logic [3:0] f,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = f[{b[i], a[i]}];
        return r;
    endfunction

    task automatic tick();
        if (rst) begin
            ph    = 0;
            exp_o = '0;
            exp_m = '0;
        end else if (ph == 0) begin
            if (start) begin
                cap_o = ref_f(func, in0, in1);
                cap_m = cap_o ^ m_out;
                ph    = 1;
            end
        end else begin
            if (ph == 2) begin
                exp_o = cap_o;
                exp_m = cap_m;
            end
            ph = (ph + 1) % 4;
        end
        @(posedge clk);
        #1;
        check("ready", 32'(ready), 32'(ph == 0));
        check("out_valid", 32'(out_valid), 32'(ph == 3));
        check("out", 32'(out), 32'(exp_o));
        check("out_m", 32'(out_m), 32'(exp_m));
    endtask

    task automatic set_op(input logic [3:0] f, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] ma,
                          input logic [7:0] mb, input logic [7:0] mo);
        func  = f;
        in0   = a;
        in1   = b;
        m_in0 = ma;
        m_in1 = mb;
        m_out = mo;
    endtask

    task automatic run_op();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        set_op(4'b0001, 8'hF0, 8'hCC, 8'h00, 8'h00, 8'h00);
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_out", 32'(out), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();

        // NOR, unmasked
        run_op();
        check("nor_out", 32'(out), 32'h03);
        check("nor_out_m", 32'(out_m), 32'h03);

        // NOR, masked
        set_op(4'b0001, 8'hF0, 8'hCC, 8'hA5, 8'h3C, 8'hFF);
        run_op();
        check("nor_m_out", 32'(out), 32'h03);
        check("nor_m_out_m", 32'(out_m), 32'hFC);

        // XOR, masked
        set_op(4'b0110, 8'hAA, 8'h0F, 8'h5A, 8'hC3, 8'h96);
        run_op();
        check("xor_out", 32'(out), 32'hA5);
        check("xor_out_m", 32'(out_m), 32'h33);

        // start held high, AND
        set_op(4'b1000, 8'hFF, 8'h81, 8'h00, 8'h00, 8'h00);
        start = 1'b1;
        repeat (16) tick();
        start = 1'b0;
        check("and_out", 32'(out), 32'h81);

        // Inputs changed during PRE must not matter
        set_op(4'b0111, 8'hFF, 8'hFF, 8'h33, 8'h55, 8'h0F);
        start = 1'b1;
        tick();
        start = 1'b0;
        in0   = 8'h00;
        func  = 4'b0001;
        repeat (3) tick();
        check("nand_hold_out", 32'(out), 32'h00);

        // rst during EVAL aborts the op
        set_op(4'b0110, 8'h3C, 8'h0F, 8'h12, 8'h34, 8'h56);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_out", 32'(out), 32'd0);
        tick();
        set_op(4'b1110, 8'h0C, 8'h30, 8'hFF, 8'h0F, 8'hAA);
        run_op();
        check("post_abort_out", 32'(out), 32'h3C);

        // Random traffic, including mid-op rst and start
        for (int n = 0; n < 400; n++) begin
            start = ($urandom_range(0, 1) == 1);
            rst   = ($urandom_range(0, 24) == 0);
            set_op(4'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
